mult_sequencer_gen: RTL

- Parametrised control sequencer for an N-bit iterative multiplier datapath.
- Supports unsigned add-shift mode and signed radix-2 Booth mode.
- Issues exactly one datapath command per cycle (load, add_shift, sub_shift, shift) and reports ready/busy/done to the surrounding controller.
- Sits between the top-level start logic and the accumulator/multiplier shift register.

---
 rtl/mult_sequencer_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/mult_sequencer_gen.sv
// Control sequencer for an n-bit iterative multiplier: issues one datapath
// command per cycle in unsigned add-shift or signed radix-2 Booth mode.
module mult_sequencer_gen #(
  parameter int n = 8,
  localparam int CW = $clog2(n + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          signed_mode,
  input  logic          Q0,
  input  logic          Qm1,
  output logic          load,
  output logic          add_shift,
  output logic          sub_shift,
  output logic          shift,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          mode_q,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      mode_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            mode_q <= signed_mode;
          end
        end
        LOAD: begin
          state <= EVAL;
          count <= CW'(n);
        end
        EVAL: begin
          count <= count - CW'(1);
          // count reaches 0 together with the last op, so it never wraps
          if (count == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // start must be seen low before another multiply can begin
          if (!start) state <= IDLE;
        end
      endcase
    end
  end

  // Commands: load is Moore in LOAD, EVAL ops follow the live Q0/Qm1 bits
  always_comb begin
    load      = 1'b0;
    add_shift = 1'b0;
    sub_shift = 1'b0;
    shift     = 1'b0;
    case (state)
      LOAD: load = 1'b1;
      EVAL: begin
        if (mode_q) begin
          case ({Q0, Qm1})
            2'b10:   sub_shift = 1'b1;
            2'b01:   add_shift = 1'b1;
            default: shift     = 1'b1;
          endcase
        end else if (Q0) begin
          add_shift = 1'b1;
        end else begin
          shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == LOAD) || (state == EVAL);

endmodule
